argmin_stream: RTL and testbench

//  Streaming argmin for the k-means assignment step. Distances for K classes arrive

---
 rtl/argmin_stream.sv | 79 +++++++
 tb/tb_argmin_stream.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/argmin_stream.sv
// argmin_stream: streaming argmin over K class distances delivered LANES per beat
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   clear            synchronous abort of the partial point (held result kept)
//   in_valid/ready   input beat handshake; in_dists carries LANES unsigned DW-bit lanes
//   out_valid/ready  result handshake; out_idx = class of minimum, out_dist = minimum
module argmin_stream #(
  parameter int DW    = 32,
  parameter int K     = 256,
  parameter int LANES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_dists,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_idx,
  output logic [DW-1:0]       out_dist
);
  localparam int BEATS = K / LANES;
  localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int NODES = 2 * LANES - 1;
  // Heap-ordered comparison tree: leaves at LANES-1.., node n has children 2n+1 (lower lanes) and 2n+2.
  logic [DW-1:0] node_min [NODES];
  logic [31:0]   node_idx [NODES];
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [DW-1:0] run_min_q, run_min_d, out_dist_q, out_dist_d, new_min;
  logic [31:0]   run_idx_q, run_idx_d, out_idx_q, out_idx_d, new_idx;
  logic          out_valid_q, out_valid_d, accept, last, take;
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      node_min[LANES-1+l] = in_dists[l*DW +: DW];
      node_idx[LANES-1+l] = 32'(l);
    end
    // Right child wins only when strictly smaller, so ties resolve to the lower lane.
    for (int n = LANES - 2; n >= 0; n--) begin
      node_min[n] = node_min[2*n+2] < node_min[2*n+1] ? node_min[2*n+2] : node_min[2*n+1];
      node_idx[n] = node_min[2*n+2] < node_min[2*n+1] ? node_idx[2*n+2] : node_idx[2*n+1];
    end
  end
  assign in_ready = !clear && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = beat_cnt_q == CW'(BEATS - 1);
  // First beat of a point overwrites the running minimum; later beats replace it only when strictly smaller.
  assign take     = beat_cnt_q == '0 || node_min[0] < run_min_q;
  assign new_min  = take ? node_min[0] : run_min_q;
  assign new_idx  = take ? 32'(beat_cnt_q) * 32'(LANES) + node_idx[0] : run_idx_q;
  always_comb begin
    beat_cnt_d  = clear ? '0 : accept ? (last ? '0 : beat_cnt_q + CW'(1)) : beat_cnt_q;
    run_min_d   = clear ? '1 : accept ? new_min : run_min_q;
    run_idx_d   = !clear && accept ? new_idx : run_idx_q;
    out_valid_d = accept && last ? 1'b1 : out_valid_q && !out_ready;
    out_dist_d  = accept && last ? new_min : out_dist_q;
    out_idx_d   = accept && last ? new_idx : out_idx_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt_q  <= '0;
      run_min_q   <= '1;
      run_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_dist_q  <= '1;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      run_min_q   <= run_min_d;
      run_idx_q   <= run_idx_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_dist_q  <= out_dist_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_dist  = out_dist_q;
endmodule

// File: tb/tb_argmin_stream.sv
// tb_argmin_stream: directed checks on K=8/LANES=4 plus a randomised K=LANES=16 throughput run
module tb_argmin_stream;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [31:0] a_in_dists = '0, a_out_idx;
  logic [7:0] a_out_dist;
  logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [127:0] b_in_dists = '0;
  logic [31:0] b_out_idx;
  logic [7:0] b_out_dist;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  argmin_stream #(.DW(8), .K(8), .LANES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_dists(a_in_dists), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_idx(a_out_idx), .out_dist(a_out_dist));
  argmin_stream #(.DW(8), .K(16), .LANES(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_dists(b_in_dists), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_idx(b_out_idx), .out_dist(b_out_dist));
  function automatic logic [31:0] pack(input logic [7:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_out_dist !== 8'hFF) begin errors++; $display("FAIL reset_dist got=%0h exp=ff", a_out_dist); end
    checks++; if (a_out_idx !== 32'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", a_out_idx); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", a_in_ready); end
    rst_n = 1'b1;
    cyc();
  endtask
  task automatic test_basic();
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    a_in_dists = pack(9, 3, 7, 5);
    cyc();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL basic_early got=%0b exp=0", a_out_valid); end
    a_in_dists = pack(6, 2, 8, 4);
    cyc();
    a_in_valid = 1'b0;
    checks++; if ({a_out_valid, a_out_idx, a_out_dist} !== {1'b1, 32'd5, 8'd2}) begin errors++; $display("FAIL basic_result got=%0b/%0d/%0d exp=1/5/2", a_out_valid, a_out_idx, a_out_dist); end
    cyc();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%0b exp=0", a_out_valid); end
  endtask
  task automatic test_ties();
    a_in_valid = 1'b1;
    a_in_dists = pack(4, 1, 1, 9);
    cyc();
    a_in_dists = pack(1, 7, 7, 7);
    cyc();
    a_in_valid = 1'b0;
    checks++; if ({a_out_valid, a_out_idx, a_out_dist} !== {1'b1, 32'd1, 8'd1}) begin errors++; $display("FAIL ties_result got=%0b/%0d/%0d exp=1/1/1", a_out_valid, a_out_idx, a_out_dist); end
    cyc();
  endtask
  task automatic test_stall();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_dists = pack(9, 3, 7, 5);
    cyc();
    a_in_dists = pack(6, 2, 8, 4);
    cyc();
    checks++; if ({a_out_valid, a_out_idx, a_out_dist} !== {1'b1, 32'd5, 8'd2}) begin errors++; $display("FAIL stall_first got=%0b/%0d/%0d exp=1/5/2", a_out_valid, a_out_idx, a_out_dist); end
    a_in_dists = pack(7, 6, 5, 4);
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got=%0b exp=0", a_in_ready); end
    cyc();
    cyc();
    checks++; if ({a_out_valid, a_out_idx, a_out_dist} !== {1'b1, 32'd5, 8'd2}) begin errors++; $display("FAIL stall_hold got=%0b/%0d/%0d exp=1/5/2", a_out_valid, a_out_idx, a_out_dist); end
    a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%0b exp=1", a_in_ready); end
    cyc();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stall_consumed got=%0b exp=0", a_out_valid); end
    a_in_dists = pack(3, 9, 9, 9);
    cyc();
    a_in_valid = 1'b0;
    checks++; if ({a_out_valid, a_out_idx, a_out_dist} !== {1'b1, 32'd4, 8'd3}) begin errors++; $display("FAIL stall_second got=%0b/%0d/%0d exp=1/4/3", a_out_valid, a_out_idx, a_out_dist); end
    cyc();
  endtask
  task automatic test_clear();
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    a_in_dists = pack(0, 0, 0, 0);
    cyc();
    clear = 1'b1;
    a_in_dists = pack(1, 1, 1, 1);
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready got=%0b exp=0", a_in_ready); end
    cyc();
    clear = 1'b0;
    a_in_dists = pack(5, 5, 5, 0);
    cyc();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL clear_no_result got=%0b exp=0", a_out_valid); end
    a_in_dists = pack(5, 5, 5, 5);
    cyc();
    a_in_valid = 1'b0;
    checks++; if ({a_out_valid, a_out_idx, a_out_dist} !== {1'b1, 32'd3, 8'd0}) begin errors++; $display("FAIL clear_result got=%0b/%0d/%0d exp=1/3/0", a_out_valid, a_out_idx, a_out_dist); end
    cyc();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_dists = pack(2, 2, 2, 2);
    cyc();
    cyc();
    a_in_valid = 1'b0;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    checks++; if ({a_out_valid, a_out_idx, a_out_dist} !== {1'b1, 32'd0, 8'd2}) begin errors++; $display("FAIL clear_keeps_held got=%0b/%0d/%0d exp=1/0/2", a_out_valid, a_out_idx, a_out_dist); end
    a_out_ready = 1'b1;
    cyc();
  endtask
  task automatic test_reset_mid();
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_in_dists = pack(3, 3, 3, 3);
    cyc();
    cyc();
    a_in_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    checks++; if ({a_out_valid, a_out_idx, a_out_dist} !== {1'b0, 32'd0, 8'hFF}) begin errors++; $display("FAIL rstmid_held got=%0b/%0d/%0h exp=0/0/ff", a_out_valid, a_out_idx, a_out_dist); end
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    a_in_dists = pack(0, 0, 0, 0);
    cyc();
    rst_n = 1'b0;
    a_in_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
    a_in_valid = 1'b1;
    a_in_dists = pack(5, 5, 5, 5);
    cyc();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_cnt got=%0b exp=0", a_out_valid); end
    a_in_dists = pack(5, 5, 2, 5);
    cyc();
    a_in_valid = 1'b0;
    checks++; if ({a_out_valid, a_out_idx, a_out_dist} !== {1'b1, 32'd6, 8'd2}) begin errors++; $display("FAIL rstmid_result got=%0b/%0d/%0d exp=1/6/2", a_out_valid, a_out_idx, a_out_dist); end
    cyc();
  endtask
  task automatic test_back_to_back();
    a_out_ready = 1'b1;
    a_in_valid = 1'b1;
    a_in_dists = pack(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    cyc();
    cyc();
    checks++; if ({a_out_valid, a_out_idx, a_out_dist} !== {1'b1, 32'd0, 8'hFF}) begin errors++; $display("FAIL b2b_allones got=%0b/%0d/%0h exp=1/0/ff", a_out_valid, a_out_idx, a_out_dist); end
    a_in_dists = pack(9, 9, 9, 9);
    cyc();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%0b exp=0", a_out_valid); end
    a_in_dists = pack(9, 9, 9, 8);
    cyc();
    a_in_valid = 1'b0;
    checks++; if ({a_out_valid, a_out_idx, a_out_dist} !== {1'b1, 32'd7, 8'd8}) begin errors++; $display("FAIL b2b_second got=%0b/%0d/%0d exp=1/7/8", a_out_valid, a_out_idx, a_out_dist); end
    cyc();
  endtask
  task automatic test_random();
    logic [7:0] d [16];
    logic [7:0] exp_d;
    logic [31:0] exp_i;
    b_out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      for (int l = 0; l < 16; l++) begin
        d[l] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
        b_in_dists[l*8 +: 8] = d[l];
      end
      exp_d = d[0];
      exp_i = 0;
      for (int l = 1; l < 16; l++)
        if (d[l] < exp_d) begin
          exp_d = d[l];
          exp_i = 32'(l);
        end
      b_in_valid = 1'b1;
      checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL rand_in_ready[%0d] got=%0b exp=1", i, b_in_ready); end
      cyc();
      checks++; if ({b_out_valid, b_out_idx, b_out_dist} !== {1'b1, exp_i, exp_d}) begin errors++; $display("FAIL rand_result[%0d] got=%0b/%0d/%0d exp=1/%0d/%0d", i, b_out_valid, b_out_idx, b_out_dist, exp_i, exp_d); end
    end
    b_in_valid = 1'b0;
    cyc();
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain got=%0b exp=0", b_out_valid); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_stall();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
